multicycle_controller: RTL

//  Control FSM for the multicycle MIPS core; successor of the single-cycle controller.

---
 rtl/multicycle_controller.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//   Control FSM for the multicycle MIPS core. Each instruction is sequenced
//   over 3-5 states, plus wait cycles while memory is not ready. Only the
//   state is registered. Every datapath control is a combinational function
//   of state, opcode, funct, zero and mem_ready.
//
//   Handshake: an access is issued in FETCH, MEMRD or MEMWR. It completes in
//   the cycle where mem_ready is high, and the FSM stays in that state until
//   then. mem_ready is ignored in every other state.
//
// Parameters
//   EN_EXT     1: decode bne/andi/ori, 0: treat those opcodes as illegal
//   ALU_CW     width of alu_cntrl (>=3), zero-extended 3-bit codes
// Ports
//   clk, reset             rising-edge clock, async active-high reset
//   opcode, funct, zero    instruction fields and ALU zero flag
//   mem_ready              memory completes the current access this cycle
//   iord .. alu_cntrl      datapath mux selects, write strobes, ALU control
//   illegal                one-cycle pulse on an unsupported opcode/funct
//   state_o                current state encoding (debug)
// ---------------------------------------------------------------------------
module multicycle_controller #(
    parameter int EN_EXT = 1,
    parameter int ALU_CW = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic              zero,
    input  logic              mem_ready,
    output logic              iord,
    output logic              ir_write,
    output logic              pc_en,
    output logic              we_mem,
    output logic              we_regf,
    output logic              reg_dst,
    output logic              mem_to_reg,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic              imm_zext,
    output logic [1:0]        pc_src,
    output logic [ALU_CW-1:0] alu_cntrl,
    output logic              illegal,
    output logic [3:0]        state_o
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BEQ     = 4'd8,
        S_ADDIEX  = 4'd9,
        S_IMMWB   = 4'd10,
        S_JUMP    = 4'd11,
        S_BNE     = 4'd12,
        S_LOGIEX  = 4'd13
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] alu3;
    logic       ext_en;

    assign ext_en = (EN_EXT != 0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_en      = 1'b0;
        we_mem     = 1'b0;
        we_regf    = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        imm_zext   = 1'b0;
        pc_src     = 2'b00;
        alu3       = ALU_ADD;
        illegal    = 1'b0;

        case (state_q)
            S_FETCH: begin
                // PC + 4 is computed every cycle and committed only when
                // the instruction word arrives.
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_en    = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target (PC + imm<<2) goes into ALUOut speculatively.
                alu_src_b = 2'b11;
                case (opcode)
                    OP_R:         state_d = S_EXECUTE;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    OP_BNE: begin
                        if (ext_en) begin
                            state_d = S_BNE;
                        end else begin
                            illegal = 1'b1;
                            state_d = S_FETCH;
                        end
                    end
                    OP_ANDI, OP_ORI: begin
                        if (ext_en) begin
                            state_d = S_LOGIEX;
                        end else begin
                            illegal = 1'b1;
                            state_d = S_FETCH;
                        end
                    end
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                // The instruction register still holds the opcode, so the
                // load/store choice is made again here.
                state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                we_regf    = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                // Write strobe is held for the whole access, not just the
                // completing cycle.
                iord   = 1'b1;
                we_mem = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                state_d   = S_ALUWB;
                case (funct)
                    FN_ADD:  alu3 = ALU_ADD;
                    FN_SUB:  alu3 = ALU_SUB;
                    FN_AND:  alu3 = ALU_AND;
                    FN_OR:   alu3 = ALU_OR;
                    FN_SLT:  alu3 = ALU_SLT;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_ALUWB: begin
                we_regf = 1'b1;
                reg_dst = 1'b1;
                state_d = S_FETCH;
            end
            S_BEQ, S_BNE: begin
                alu_src_a = 1'b1;
                alu3      = ALU_SUB;
                pc_src    = 2'b01;
                pc_en     = (state_q == S_BEQ) ? zero : ~zero;
                state_d   = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_IMMWB;
            end
            S_LOGIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                imm_zext  = 1'b1;
                alu3      = (opcode == OP_ORI) ? ALU_OR : ALU_AND;
                state_d   = S_IMMWB;
            end
            S_IMMWB: begin
                we_regf = 1'b1;
                state_d = S_FETCH;
            end
            S_JUMP: begin
                pc_src  = 2'b10;
                pc_en   = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // The state is already FETCH during reset, so only the strobes that
        // FETCH could raise from mem_ready need masking.
        if (reset) begin
            ir_write = 1'b0;
            pc_en    = 1'b0;
            we_mem   = 1'b0;
            we_regf  = 1'b0;
            illegal  = 1'b0;
        end
    end

    assign alu_cntrl = ALU_CW'(alu3);
    assign state_o   = state_q;

endmodule
